// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ENTRY_OPEN = 2'd1,
    ST_EXIT_OPEN  = 2'd2
  } gate_state_e;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  localparam int DEFAULT_CAPACITY    = 8;
  localparam int DEFAULT_OPEN_CYCLES = 100;

endpackage

// File: rtl/gate_hold_timer.sv
// Counts the barrier-open window; done marks the final open cycle.
module gate_hold_timer #(
  parameter int OPEN_CYCLES = 100,
  parameter int TMR_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  assign done = run_q && (cnt_q == TMR_W'(OPEN_CYCLES - 1));

  // Load on start, count while running, park at zero once the window ends.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      cnt_d = '0;
      run_d = 1'b1;
    end else if (done) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q + TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Timer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Arbitrates the shared barrier between entry and exit lanes and tracks lot occupancy.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEFAULT_CAPACITY,
  parameter int CNT_W       = 4,
  parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES,
  parameter int TMR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             entry_denied,
  output logic             busy
);

  gate_state_e      state_q, state_d;
  logic             entry_pend_q, entry_pend_d;
  logic             exit_pend_q, exit_pend_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             gate_open_q, gate_dir_q, full_q, empty_q, denied_q, busy_q;
  logic             denied_d;
  logic             eff_entry_s, eff_exit_s;
  logic             start_s, done_s;

  assign eff_entry_s = entry_pend_q | entry_req;
  assign eff_exit_s  = exit_pend_q | exit_req;

  gate_hold_timer #(
    .OPEN_CYCLES(OPEN_CYCLES),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .start(start_s),
    .done (done_s)
  );

  // Arbitration: pulses always merge into their pending flag unless consumed in IDLE.
  always_comb begin
    state_d      = state_q;
    entry_pend_d = eff_entry_s;
    exit_pend_d  = eff_exit_s;
    occ_d        = occ_q;
    denied_d     = 1'b0;
    start_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eff_exit_s && (occ_q != '0)) begin
          state_d     = ST_EXIT_OPEN;
          occ_d       = occ_q - CNT_W'(1);
          exit_pend_d = 1'b0;
          start_s     = 1'b1;
        end else begin
          // An exit with nobody inside is dropped; entry is still evaluated.
          exit_pend_d = 1'b0;
          if (eff_entry_s) begin
            entry_pend_d = 1'b0;
            if (occ_q != CNT_W'(CAPACITY)) begin
              state_d = ST_ENTRY_OPEN;
              occ_d   = occ_q + CNT_W'(1);
              start_s = 1'b1;
            end else begin
              denied_d = 1'b1;
            end
          end else begin
            entry_pend_d = 1'b0;
          end
        end
      end
      ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
        if (done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pending flags and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      occ_q        <= '0;
      gate_open_q  <= 1'b0;
      gate_dir_q   <= DIR_ENTRY;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      denied_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      entry_pend_q <= entry_pend_d;
      exit_pend_q  <= exit_pend_d;
      occ_q        <= occ_d;
      gate_open_q  <= (state_d != ST_IDLE);
      gate_dir_q   <= (state_d == ST_EXIT_OPEN) ? DIR_EXIT : DIR_ENTRY;
      full_q       <= (occ_d == CNT_W'(CAPACITY));
      empty_q      <= (occ_d == '0);
      denied_q     <= denied_d;
      busy_q       <= (state_d != ST_IDLE) | entry_pend_d | exit_pend_d;
    end
  end

  assign gate_open    = gate_open_q;
  assign gate_dir     = gate_dir_q;
  assign occupancy    = occ_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign entry_denied = denied_q;
  assign busy         = busy_q;

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Consumes the one-cycle entry/exit pulses from the gate sensor detector.
- Arbitrates a single shared barrier between the entry and exit lanes.
- Keeps the lot occupancy count and holds the barrier open for a fixed time per car.
- Sits between the detector and the barrier actuator / status display.

Parameters:
- CAPACITY, 8: number of spaces in the lot; must be at least 1.
- CNT_W, 4: occupancy width; 2**CNT_W must be greater than CAPACITY.
- OPEN_CYCLES, 100: barrier-open time in clk cycles; must be at least 1.
- TMR_W, 8: hold-timer width; 2**TMR_W must be at least OPEN_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- entry_req  in  1  one-cycle pulse: car at the entry gate.
- exit_req  in  1  one-cycle pulse: car at the exit gate.
- gate_open  out  1  barrier open command.
- gate_dir  out  1  lane being served: 0 = entry, 1 = exit. Valid while gate_open is high.
- occupancy  out  CNT_W  cars currently inside the lot.
- full  out  1  high when occupancy == CAPACITY.
- empty  out  1  high when occupancy == 0.
- entry_denied  out  1  one-cycle pulse: an entry request was rejected because the lot is full.
- busy  out  1  high when FSM is not IDLE or any request is pending.

Behaviour:
- Reset (any time, including mid-open):
  - State = IDLE; both pending flags cleared; timer = 0.
  - gate_open = 0, gate_dir = 0, occupancy = 0, full = 0, empty = 1, entry_denied = 0, busy = 0.
- Pending flags entry_pend and exit_pend:
  - A flag is set by its request pulse and cleared when that request is granted or denied.
  - A pulse arriving while its flag is already set is merged and dropped; one flag holds at most one car.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN.
- IDLE decision uses eff_x = x_pend OR x_req, so a request pulse in cycle c can be granted in cycle c+1. Priority order:
  1. eff_exit with occupancy > 0: go to EXIT_OPEN, decrement occupancy, clear exit_pend. Exit has priority because it frees a space.
  2. eff_exit with occupancy == 0: clear exit_pend silently; no gate action. In the same cycle, evaluate entry normally.
  3. eff_entry, not full: go to ENTRY_OPEN, increment occupancy, clear entry_pend.
  4. eff_entry, full: clear entry_pend, pulse entry_denied in the next cycle, stay in IDLE.
- Simultaneous events:
  - Exit and entry together while full: exit is served first, and the entry stays pending.
  - That pending entry is granted after the exit cycle completes, because the lot is no longer full at that point.
- Open states:
  - gate_open = 1; gate_dir is set per state.
  - Timer loads 0 on entry and increments each cycle.
  - Exit to IDLE after exactly OPEN_CYCLES cycles of gate_open high.
  - IDLE always lasts at least one cycle, so gate_open is low for at least one cycle between services.
- Requests arriving during an open state are latched and served in priority order from the next IDLE.
- Occupancy changes in the same edge as the IDLE→OPEN transition. full and empty are registered and consistent with occupancy in the same cycle.
- Occupancy is saturating by construction and never wraps: no increment happens at CAPACITY and no decrement at 0.
- All outputs are registered.

Decomposition:
- Shared package parking_pkg:
  - FSM state enum (IDLE, ENTRY_OPEN, EXIT_OPEN).
  - Constants DIR_ENTRY = 0 and DIR_EXIT = 1.
  - Default CAPACITY and OPEN_CYCLES values.
- One natural sub-module, gate_hold_timer:
  - Inputs: start, clk, reset.
  - Output: done, asserted in the final open cycle.
- Occupancy counter and arbitration stay in the top module.

Test Plan (CAPACITY = 2, OPEN_CYCLES = 4):
1. Reset, then an entry_req pulse in cycle 0 → gate_open = 1 with gate_dir = 0 in cycles 1-4, gate_open = 0 in cycle 5, occupancy = 1, empty = 0.
2. Two entries to fill the lot, then a third entry_req → entry_denied is a single one-cycle pulse, gate stays closed, occupancy stays 2, full = 1.
3. Lot full; entry_req and exit_req in the same cycle → exit served first (gate_dir = 1, occupancy goes to 1). After at least one IDLE cycle, entry served (gate_dir = 0, occupancy goes to 2). No entry_denied.
4. exit_req while empty → no gate_open, occupancy stays 0, busy returns to 0 the next cycle.
5. entry_req pulsed twice during an open window → exactly one additional entry service, and occupancy increments by 1 only.
6. Assert reset during the 2nd open cycle → gate_open = 0 and occupancy = 0 immediately (asynchronously, not waiting for the clock edge); a subsequent entry_req behaves as in test 1.
